// File: rtl/led_shift_engine.sv
// LED pattern engine: prescaled shift/rotate register with synchronised buttons.
// Define LED_SHIFT_ENGINE_GRAY_EN to add mode 4 (Gray counter).
module led_shift_engine #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       key,
  output logic [WIDTH-1:0] led,
  output logic [2:0]       mode,
  output logic             tick
);

  localparam logic [2:0] M_SHR = 3'd0;
  localparam logic [2:0] M_SHL = 3'd1;
  localparam logic [2:0] M_ROR = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
`ifdef LED_SHIFT_ENGINE_GRAY_EN
  localparam logic [2:0] M_GRAY = 3'd4;
  localparam logic [2:0] M_LAST = M_GRAY;
`else
  localparam logic [2:0] M_LAST = M_ROL;
`endif

  logic [2:0]       key_m;
  logic [2:0]       key_s;
  logic             adv_q;
  logic [DIV_W-1:0] cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] nxt;
  logic             din;
  logic             clr;
  logic             adv;

  assign din  = ~key_s[0];
  assign clr  = ~key_s[2];
  assign adv  = adv_q & ~key_s[1];
  assign tick = &cnt;
  assign led  = ~shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m <= 3'b111;
      key_s <= 3'b111;
      adv_q <= 1'b1;
    end else begin
      key_m <= key;
      key_s <= key_m;
      adv_q <= key_s[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

`ifdef LED_SHIFT_ENGINE_GRAY_EN
  logic [WIDTH-1:0] gbin;
  logic [WIDTH-1:0] ginc;

  assign ginc = gbin + 1'b1;

  // Restart the count each time the mode is entered so the pattern starts at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gbin <= '0;
    else if (clr || (adv && mode == M_ROL))
      gbin <= '0;
    else if (tick && mode == M_GRAY)
      gbin <= ginc;
  end
`endif

  always_comb begin
    nxt = shift_reg;
    unique case (mode)
      M_SHR:   nxt = {din, shift_reg[WIDTH-1:1]};
      M_SHL:   nxt = {shift_reg[WIDTH-2:0], din};
      M_ROR:   nxt = {shift_reg[0] | din, shift_reg[WIDTH-1:1]};
      M_ROL:   nxt = {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1] | din};
`ifdef LED_SHIFT_ENGINE_GRAY_EN
      M_GRAY:  nxt = ginc ^ (ginc >> 1);
`endif
      default: nxt = shift_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    shift_reg <= '0;
    else if (clr)  shift_reg <= '0;
    else if (tick) shift_reg <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mode <= M_SHR;
    else if (adv)
      mode <= (mode == M_LAST) ? M_SHR : mode + 3'd1;
  end

endmodule

// File: tb/tb_led_shift_engine.sv
// Self-checking bench for led_shift_engine (WIDTH=8, DIV_W=3).
// Directed vector table, hand sequences and random keys against a delay-history model.
module tb_led_shift_engine;

  localparam int W  = 8;
  localparam int DW = 3;
`ifdef LED_SHIFT_ENGINE_GRAY_EN
  localparam int NM = 5;
`else
  localparam int NM = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   key = 3'b111;
  logic [W-1:0] led;
  logic [2:0]   mode;
  logic         tick;

  int checks = 0;
  int failures = 0;

  int         n;
  logic [2:0] hist[$];
  int         m_reg;
  int         m_mode;
  int         m_gbin;

  typedef struct {
    logic [2:0] k;
    int         cycles;
    logic [7:0] led;
    logic [2:0] mode;
  } vec_t;

  vec_t tbl[$];

  led_shift_engine #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key(key),
    .led(led),
    .mode(mode),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    hist = {3'b111, 3'b111, 3'b111};
    m_reg = 0;
    m_mode = 0;
    m_gbin = 0;
  endtask

  // hist[n+3] holds the raw key seen at edge n; logic acts on raw from 2 edges back
  task automatic model_edge();
    logic [2:0] k2;
    logic [2:0] k3;
    int din, g;
    bit clr, adv, tk;
    k2 = hist[n+1];
    k3 = hist[n];
    din = k2[0] ? 0 : 1;
    clr = !k2[2];
    adv = k3[1] && !k2[1];
    tk = (n % 8) == 7;
    g = (m_gbin + 1) % 256;
    if (clr) m_reg = 0;
    else if (tk) begin
      case (m_mode)
        0: m_reg = (m_reg / 2) + din * 128;
        1: m_reg = ((m_reg * 2) % 256) + din;
        2: m_reg = (m_reg / 2) + (((m_reg % 2) | din) * 128);
        3: m_reg = ((m_reg * 2) % 256) + ((m_reg / 128) | din);
        default: m_reg = g ^ (g / 2);
      endcase
    end
    if (clr || (adv && m_mode == 3)) m_gbin = 0;
    else if (tk && m_mode == 4) m_gbin = g;
    if (adv) m_mode = (m_mode + 1) % NM;
    n++;
  endtask

  task automatic cyc(input logic [2:0] k);
    key = k;
    hist.push_back(k);
    @(posedge clk);
    model_edge();
    #1;
    check("led", int'(led), (~m_reg) & 255);
    check("mode", int'(mode), m_mode);
    check("tick", int'(tick), ((n % 8) == 7) ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    key = 3'b111;
    #1;
    check("reset led", int'(led), 255);
    check("reset mode", int'(mode), 0);
    check("reset tick", int'(tick), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [2:0] k;
    logic [7:0] gexp[4];

    tbl.push_back('{3'b110, 24, 8'h1F, 3'd0});
    tbl.push_back('{3'b011,  8, 8'hFF, 3'd0});
    tbl.push_back('{3'b101,  3, 8'hFF, 3'd1});
    tbl.push_back('{3'b111,  2, 8'hFF, 3'd1});
    tbl.push_back('{3'b110,  1, 8'hFF, 3'd1});
    tbl.push_back('{3'b111,  2, 8'hFE, 3'd1});
    tbl.push_back('{3'b111, 16, 8'hFB, 3'd1});
    tbl.push_back('{3'b001,  1, 8'hFB, 3'd1});
    tbl.push_back('{3'b011,  1, 8'hFB, 3'd1});
    tbl.push_back('{3'b001,  1, 8'hFF, 3'd2});
    tbl.push_back('{3'b011,  1, 8'hFF, 3'd2});
    tbl.push_back('{3'b001,  1, 8'hFF, 3'd3});
    tbl.push_back('{3'b011,  1, 8'hFF, 3'd3});
    tbl.push_back('{3'b111,  1, 8'hFF, 3'd0});
    tbl.push_back('{3'b111,  6, 8'hFF, 3'd0});
    tbl.push_back('{3'b110,  1, 8'hFF, 3'd0});
    tbl.push_back('{3'b111,  2, 8'h7F, 3'd0});
    tbl.push_back('{3'b101,  1, 8'h7F, 3'd0});
    tbl.push_back('{3'b111,  1, 8'h7F, 3'd0});
    tbl.push_back('{3'b101,  1, 8'h7F, 3'd1});
    tbl.push_back('{3'b111,  1, 8'h7F, 3'd1});
    tbl.push_back('{3'b111,  1, 8'h7F, 3'd2});
    tbl.push_back('{3'b111, 59, 8'h7F, 3'd2});
    tbl.push_back('{3'b111,  5, 8'h7F, 3'd2});
    tbl.push_back('{3'b101,  1, 8'h7F, 3'd2});
    tbl.push_back('{3'b111,  2, 8'hBF, 3'd3});
    tbl.push_back('{3'b111,  8, 8'h7F, 3'd3});

    do_reset();

`ifndef LED_SHIFT_ENGINE_GRAY_EN
    foreach (tbl[i]) begin
      repeat (tbl[i].cycles) cyc(tbl[i].k);
      check($sformatf("row%0d led", i), int'(led), int'(tbl[i].led));
      check($sformatf("row%0d mode", i), int'(mode), int'(tbl[i].mode));
    end
`endif

    do_reset();
    repeat (4) begin
      cyc(3'b101);
      cyc(3'b111);
    end
    cyc(3'b111);
    check("wrap4 mode", int'(mode), 4 % NM);
    cyc(3'b101);
    cyc(3'b111);
    cyc(3'b111);
    check("wrap5 mode", int'(mode), 5 % NM);

`ifdef LED_SHIFT_ENGINE_GRAY_EN
    do_reset();
    gexp = '{8'h01, 8'h03, 8'h02, 8'h06};
    repeat (4) begin
      cyc(3'b101);
      cyc(3'b111);
    end
    cyc(3'b111);
    check("gray enter mode", int'(mode), 4);
    repeat (6) cyc(3'b111);
    for (int t = 0; t < 4; t++) begin
      repeat (8) cyc(3'b111);
      check($sformatf("gray tick%0d", t), int'(led), int'(~gexp[t]));
    end
`endif

    for (int i = 0; i < 800; i++) begin
      k[0] = ($urandom_range(1) == 0);
      k[1] = ($urandom_range(7) != 0);
      k[2] = ($urandom_range(15) != 0);
      cyc(k);
    end

    do_reset();
    for (int i = 0; i < 200; i++) begin
      k[0] = ($urandom_range(1) == 0);
      k[1] = ($urandom_range(5) != 0);
      k[2] = ($urandom_range(31) != 0);
      cyc(k);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async led", int'(led), 255);
    check("async mode", int'(mode), 0);
    check("async tick", int'(tick), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_shift_engine.md
# led_shift_engine

Parametrised LED pattern engine for the small-CPLD demo boards: a prescaled shift register with four runtime-selectable modes (shift right, shift left, rotate right, rotate left) plus an optional Gray-counter mode. Raw active-low push-buttons are synchronised internally. The block drives active-low LEDs directly and sits between the board's `top` pin wrapper and the LED pins.

## Interface

Parameters:

- `WIDTH`, default 8: register and LED width; must be ≥ 2.
- `DIV_W`, default 23: prescaler width; one shift tick every 2^DIV_W clocks; must be ≥ 1.

Ports:

- `clk`  input  1: single clock; all state is on its rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `key`  input  3: raw active-low buttons.
  - `key[0]`: serial data, level, 0 = pressed = insert 1.
  - `key[1]`: mode advance, acts on the press edge.
  - `key[2]`: clear, level.
- `led`  output  WIDTH: active-low LED drive, `led = ~shift_reg`.
- `mode`  output  3: current mode code.
- `tick`  output  1: prescaler strobe, one clock wide.

## Operation

- **Synchroniser.** Each `key` bit goes through a 2-flop synchroniser that resets to 1 (released). `din = ~key_s[0]`, `clr = ~key_s[2]`. Advance fires on a 1→0 transition of `key_s[1]`, detected with a third flop (reset 1).
- **Prescaler.** `cnt` is DIV_W bits, resets to 0 and increments every clock. It wraps freely and is not affected by clear or mode. `tick = (cnt == all-ones)`.
- **Register update.** On each cycle with `tick` and no `clr`, the register updates according to the mode in effect (current value of `mode`):
  - 0 SHR: `{din, r[W-1:1]}`
  - 1 SHL: `{r[W-2:0], din}`
  - 2 ROR: `{r[0] | din, r[W-1:1]}`
  - 3 ROL: `{r[W-2:0], r[W-1] | din}`
- **Clear.** While `clr` is active, `shift_reg <= 0` every clock. Clear has priority over tick. Mode and `cnt` are unaffected.
- **Mode advance.** One advance event sets `mode <= mode + 1`, wrapping after the last implemented mode. Register contents are unchanged by a mode change.
- **Simultaneous events.**
  - Advance and tick in the same cycle: the tick uses the old mode; the new mode applies from the next cycle.
  - Advance and clear in the same cycle: both take effect.
- **Reset.** Asserting reset at any time forces, immediately and without a clock edge:
  - `shift_reg = 0`, so `led` = all-ones (all LEDs off)
  - `mode = 0`
  - `cnt = 0`, so `tick = 0` (DIV_W ≥ 1)
  - synchroniser and edge flops = 1
  - Gray counter (when compiled in) = 0

## Timing

- A raw key change is visible at `key_s` after 2 rising edges.
  - Clear zeroes the register on the 3rd edge.
  - `mode` changes on the 3rd edge after the press.
- `din` used at a tick edge reflects the raw `key[0]` level from 2 edges earlier.
- After reset release, the first `tick` is high during clock 2^DIV_W − 1, counting the first clock after release as 0. The register first changes at the end of that clock.
- `led` and `mode` are registered state with no combinational path from `key`. `tick` decodes directly from `cnt`.
- Button bounce is not filtered. Each bounce edge on `key[1]` counts as an advance; debouncing is done by the board wrapper if required.

## Configuration

- `LED_SHIFT_ENGINE_GRAY_EN` not defined: modes 0–3 only; mode sequence 0→1→2→3→0.
- `LED_SHIFT_ENGINE_GRAY_EN` defined: adds mode 4 GRAY; mode sequence 0→1→2→3→4→0.
  - Adds a WIDTH-bit binary counter `gbin` (reset 0), cleared on the cycle the advance enters mode 4 and on `clr`.
  - On each tick in mode 4: `gbin <= gbin + 1` and `shift_reg <= (gbin+1) ^ ((gbin+1) >> 1)`, wrapping modulo 2^WIDTH.
  - `din` is ignored in mode 4.

## Test plan

All scenarios use WIDTH=8, DIV_W=3, so a tick occurs every 8 clocks.

1. **Reset values.** Assert `rst_n` low between clock edges → `led` = 8'hFF, `mode` = 0, `tick` = 0 immediately. Release, then hold `key[0]` low for 3 ticks in SHR → `led` = 8'h1F (register 8'hE0).
2. **SHL.** One `key[1]` press → `mode` = 1 on the 3rd edge. Hold `key[0]` low for one tick, release, wait 2 more ticks → register 8'h04, `led` = 8'hFB.
3. **ROR loop.** Load 8'h80 in SHR (one tick with `key[0]` low). Advance to mode 2, wait 8 ticks with `key[0]` released → register back to 8'h80 and never 0 in between.
4. **Clear priority.** With register 8'hE0, hold `key[2]` low across a tick → `led` = 8'hFF; `mode` and `tick` cadence unchanged.
5. **Mode wrap and same-cycle advance.**
   - Press `key[1]` 4 times → `mode` = 0 without the macro.
   - Time an advance to land on a tick edge → that shift uses the old mode.
6. **GRAY (macro defined).** Advance to mode 4 → successive ticks give registers 8'h01, 8'h03, 8'h02, 8'h06. Five presses from mode 0 → `mode` = 0.
